regfile_scoreboard: RTL and testbench
=====================================

// Module: regfile_scoreboard
// PURPOSE
//   Parametrised integer register file for the pipelined RV32I core, successor to the fixed 2-read regfile.
//   N combinational read ports, one writeback port, x0 hardwired to zero, a0 debug tap, synchronised trigger input.
//   Adds a per-register busy scoreboard (set at issue, cleared at writeback) for hazard/stall detection in decode.
//   Sits in ID stage: reads/scoreboard feed the hazard unit; writeback comes from WB stage.
// PARAMETERS
//   DATA_WIDTH  32  register width in bits
//   ADDR_WIDTH  5   register address width; depth = 2**ADDR_WIDTH
//   NUM_READ    2   number of read ports (>=1)
//   A0_IDX      10  register driven onto a0
//   TRIG_IDX    5   register set to 1 by a trigger event (must be !=0)
// PORTS
//   clk        in   1                     clock, all state on posedge
//   rst        in   1                     asynchronous, active-high reset
//   we         in   1                     writeback enable
//   waddr      in   ADDR_WIDTH            writeback register address
//   wdata      in   DATA_WIDTH            writeback data
//   raddr      in   NUM_READ*ADDR_WIDTH   read addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   rdata      out  NUM_READ*DATA_WIDTH   read data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   rbusy      out  NUM_READ              1 = port i register has an outstanding producer
//   issue_vld  in   1                     instruction with destination issued this cycle
//   issue_rd   in   ADDR_WIDTH            destination of issued instruction
//   flush      in   1                     pipeline flush: clear all busy bits
//   trigger    in   1                     asynchronous external trigger
//   a0         out  DATA_WIDTH            contents of register A0_IDX (no bypass)
// BEHAVIOUR
//   Reset (async, rst=1): all registers 0, all busy bits 0, trigger sync flops 0, trig_pend 0 -> a0=0, rbusy=0, rdata=0.
//   Write: posedge, we=1 and waddr!=0 -> reg[waddr]<=wdata; writes to x0 discarded. Latency: visible next cycle (see bypass).
//   Read: combinational; raddr==0 -> rdata=0 always. Ports independent; any ports may share an address.
//   Scoreboard, per posedge, precedence high->low for register r!=0:
//     issue_vld && issue_rd==r -> busy[r]<=1 (new producer beats same-cycle writeback and flush)
//     flush -> busy[r]<=0; we && waddr==r -> busy[r]<=0; else hold. busy[0] never set.
//   rbusy[i] = busy[raddr_i] & ~(we & waddr==raddr_i) & (raddr_i!=0) -- writeback this cycle resolves the hazard.
//   Trigger: 2-flop synchroniser, then rising-edge detect -> trig_pend<=1.
//     trig_pend && !(we && waddr==TRIG_IDX) -> reg[TRIG_IDX]<=1, trig_pend<=0.
//     Collision with writeback to TRIG_IDX: writeback wins that cycle, trig_pend held, set applied next free cycle.
//     Further edges while pending merge into the one pending event. Trigger does not touch busy bits.
//   a0: reg[A0_IDX] direct, reflects committed state only.
//   Reset mid-operation: all state cleared immediately; pending trigger discarded.
// CONFIGURATION
//   REGFILE_BYPASS_EN defined: rdata_i = wdata when we && waddr==raddr_i && raddr_i!=0 (write-through, same cycle).
//   Not defined: rdata_i returns pre-write value; consumer sees new value one cycle later. rbusy rule unchanged.
// TESTING
//   Reset: rst=1 mid-run after writing x3=0xDEAD -> a0=0, rdata(x3)=0, rbusy=0 immediately, before next clk.
//   x0: we=1 waddr=0 wdata=0xFFFFFFFF, raddr0=0 -> rdata0=0 same and next cycle; issue_rd=0 -> rbusy stays 0.
//   Bypass: we=1 waddr=7 wdata=0x1234, raddr1=7 same cycle -> rdata1=0x1234 with _EN, old value without; 0x1234 next cycle both.
//   Scoreboard: issue x8 -> rbusy=1 next cycle; same cycle as we x8 + new issue x8 -> rbusy stays 1; flush -> rbusy=0.
//   Trigger: pulse trigger, x5 written 1 by 3rd posedge; pulse while we waddr=5 wdata=0x9 -> x5=0x9 then x5=1 next cycle.
//   Params: NUM_READ=3, DATA_WIDTH=64 -> three ports read x1/x2/x1 correctly after 64-bit write 0xA5A5_0000_0000_5A5A.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Parametrised RV32I integer register file with per-register busy scoreboard,
// a0 debug tap and synchronised trigger. Define REGFILE_BYPASS_EN for same-cycle write-through reads.
module regfile_scoreboard #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2,
    parameter int A0_IDX     = 10,
    parameter int TRIG_IDX   = 5
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           we,
    input  logic [ADDR_WIDTH-1:0]          waddr,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] raddr,
    output logic [NUM_READ*DATA_WIDTH-1:0] rdata,
    output logic [NUM_READ-1:0]            rbusy,
    input  logic                           issue_vld,
    input  logic [ADDR_WIDTH-1:0]          issue_rd,
    input  logic                           flush,
    input  logic                           trigger,
    output logic [DATA_WIDTH-1:0]          a0
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] TRIG_ADDR = ADDR_WIDTH'(TRIG_IDX);
    localparam logic [ADDR_WIDTH-1:0] A0_ADDR   = ADDR_WIDTH'(A0_IDX);

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS_EN = 1'b1;
`else
    localparam bit BYPASS_EN = 1'b0;
`endif

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]      busy_q;
    logic [DEPTH-1:0]      busy_d;
    logic [1:0]            sync_q;
    logic [1:0]            sync_d;
    logic                  trig_pend_q;
    logic                  trig_pend_d;
    logic                  trig_rise;
    logic                  wb_hits_trig;
    logic                  trig_apply;

    // The second synchroniser stage doubles as edge history, so a pulse
    // reaches the trigger register on the third clock edge.
    always_comb begin
        sync_d       = {sync_q[0], trigger};
        trig_rise    = sync_q[0] & ~sync_q[1];
        wb_hits_trig = we && (waddr == TRIG_ADDR);
        trig_apply   = trig_pend_q && !wb_hits_trig;
        trig_pend_d  = (trig_pend_q && !trig_apply) || trig_rise;
    end

    always_comb begin
        regs_d = regs_q;
        if (trig_apply) begin
            regs_d[TRIG_ADDR] = DATA_WIDTH'(1);
        end
        if (we && (waddr != '0)) begin
            regs_d[waddr] = wdata;
        end
        regs_d[0] = '0;
    end

    // A new producer outranks both flush and a same-cycle writeback.
    always_comb begin
        busy_d = busy_q;
        for (int r = 1; r < DEPTH; r++) begin
            if (issue_vld && (issue_rd == ADDR_WIDTH'(r))) begin
                busy_d[r] = 1'b1;
            end else if (flush) begin
                busy_d[r] = 1'b0;
            end else if (we && (waddr == ADDR_WIDTH'(r))) begin
                busy_d[r] = 1'b0;
            end else begin
                busy_d[r] = busy_q[r];
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q      <= '0;
            sync_q      <= '0;
            trig_pend_q <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            sync_q      <= sync_d;
            trig_pend_q <= trig_pend_d;
        end
    end

    for (genvar i = 0; i < NUM_READ; i++) begin : g_read
        logic [ADDR_WIDTH-1:0] ra;
        logic                  wb_hit;
        logic [DATA_WIDTH-1:0] val;

        assign ra     = raddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign wb_hit = we && (waddr == ra);

        always_comb begin
            val = regs_q[ra];
            if (BYPASS_EN && wb_hit) begin
                val = wdata;
            end
            if (ra == '0) begin
                val = '0;
            end
        end

        // A writeback landing this cycle already resolves the hazard.
        assign rdata[i*DATA_WIDTH +: DATA_WIDTH] = val;
        assign rbusy[i] = busy_q[ra] & ~wb_hit & (ra != '0);
    end

    assign a0 = regs_q[A0_ADDR];

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed vector table, multi-cycle
// trigger/reset sequences, randomized run against a reference model, and a 3-port 64-bit instance.
module tb_regfile_scoreboard;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic [1:0]  rbusy;
    logic        issue_vld;
    logic [4:0]  issue_rd;
    logic        flush;
    logic        trigger;
    logic [31:0] a0;

    logic         we64;
    logic [4:0]   waddr64;
    logic [63:0]  wdata64;
    logic [14:0]  raddr64;
    logic [191:0] rdata64;
    logic [2:0]   rbusy64;
    logic         issue_vld64;
    logic [4:0]   issue_rd64;
    logic         flush64;
    logic         trigger64;
    logic [63:0]  a0_64;

    int total;
    int bad;

    regfile_scoreboard dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
        .issue_vld(issue_vld), .issue_rd(issue_rd), .flush(flush),
        .trigger(trigger), .a0(a0)
    );

    regfile_scoreboard #(.DATA_WIDTH(64), .NUM_READ(3)) dut64 (
        .clk(clk), .rst(rst), .we(we64), .waddr(waddr64), .wdata(wdata64),
        .raddr(raddr64), .rdata(rdata64), .rbusy(rbusy64),
        .issue_vld(issue_vld64), .issue_rd(issue_rd64), .flush(flush64),
        .trigger(trigger64), .a0(a0_64)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic        iv;
        logic [4:0]  ird;
        logic        fl;
        logic [31:0] exp0;
        logic [31:0] exp1;
        logic [1:0]  exp_busy;
        logic [31:0] exp_a0;
    } vec_t;

    vec_t vecs [18];

    function automatic vec_t mk(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                                input logic [4:0] r0, input logic [4:0] r1,
                                input logic iv, input logic [4:0] ird, input logic fl,
                                input logic [31:0] e0, input logic [31:0] e1,
                                input logic [1:0] eb, input logic [31:0] ea);
        vec_t v;
        v.we = w; v.waddr = wa; v.wdata = wd; v.ra0 = r0; v.ra1 = r1;
        v.iv = iv; v.ird = ird; v.fl = fl;
        v.exp0 = e0; v.exp1 = e1; v.exp_busy = eb; v.exp_a0 = ea;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                                 input logic [4:0] r0, input logic [4:0] r1,
                                 input logic iv, input logic [4:0] ird, input logic fl);
        we = w; waddr = wa; wdata = wd;
        raddr = {r1, r0};
        issue_vld = iv; issue_rd = ird; flush = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model state for the randomized phase
    logic [31:0] m_regs [32];
    bit          m_busy [32];

    function automatic logic [31:0] model_read(input logic [4:0] ra, input logic w,
                                               input logic [4:0] wa, input logic [31:0] wd);
        if (ra == 0) return 32'd0;
        if (BYP && w && wa == ra) return wd;
        return m_regs[ra];
    endfunction

    initial begin
        logic        rw;
        logic [4:0]  rwa;
        logic [31:0] rwd;
        logic [4:0]  rr0;
        logic [4:0]  rr1;
        logic        riv;
        logic [4:0]  rird;
        logic        rfl;
        logic [1:0]  exp_b;

        total = 0;
        bad = 0;
        rst = 1'b1;
        trigger = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        we64 = 0; waddr64 = 0; wdata64 = 0; raddr64 = 0;
        issue_vld64 = 0; issue_rd64 = 0; flush64 = 0; trigger64 = 0;

        vecs[0]  = mk(1, 3, 32'hDEAD, 3, 0, 0, 0, 0, BYP ? 32'hDEAD : 32'h0, 0, 2'b00, 0);
        vecs[1]  = mk(0, 0, 0, 3, 3, 0, 0, 0, 32'hDEAD, 32'hDEAD, 2'b00, 0);
        vecs[2]  = mk(0, 0, 0, 8, 3, 1, 8, 0, 0, 32'hDEAD, 2'b00, 0);
        vecs[3]  = mk(0, 0, 0, 8, 0, 0, 0, 0, 0, 0, 2'b01, 0);
        vecs[4]  = mk(1, 8, 32'h88, 8, 8, 1, 8, 0, BYP ? 32'h88 : 32'h0, BYP ? 32'h88 : 32'h0, 2'b00, 0);
        vecs[5]  = mk(0, 0, 0, 8, 8, 0, 0, 0, 32'h88, 32'h88, 2'b11, 0);
        vecs[6]  = mk(0, 0, 0, 8, 0, 0, 0, 1, 32'h88, 0, 2'b01, 0);
        vecs[7]  = mk(0, 0, 0, 8, 8, 0, 0, 0, 32'h88, 32'h88, 2'b00, 0);
        vecs[8]  = mk(1, 0, 32'hFFFFFFFF, 0, 0, 1, 0, 0, 0, 0, 2'b00, 0);
        vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
        vecs[10] = mk(1, 7, 32'h1234, 3, 7, 0, 0, 0, 32'hDEAD, BYP ? 32'h1234 : 32'h0, 2'b00, 0);
        vecs[11] = mk(0, 0, 0, 3, 7, 0, 0, 0, 32'hDEAD, 32'h1234, 2'b00, 0);
        vecs[12] = mk(0, 0, 0, 9, 7, 1, 9, 1, 0, 32'h1234, 2'b00, 0);
        vecs[13] = mk(0, 0, 0, 9, 9, 0, 0, 0, 0, 0, 2'b11, 0);
        vecs[14] = mk(1, 9, 32'h5, 9, 0, 0, 0, 0, BYP ? 32'h5 : 32'h0, 0, 2'b00, 0);
        vecs[15] = mk(0, 0, 0, 9, 9, 0, 0, 0, 32'h5, 32'h5, 2'b00, 0);
        vecs[16] = mk(1, 10, 32'hA0A0, 10, 9, 0, 0, 0, BYP ? 32'hA0A0 : 32'h0, 32'h5, 2'b00, 0);
        vecs[17] = mk(0, 0, 0, 10, 3, 0, 0, 0, 32'hA0A0, 32'hDEAD, 2'b00, 32'hA0A0);

        // Reset state
        #12;
        checkOutput("reset a0", a0, 0);
        checkOutput("reset rdata", rdata, 0);
        checkOutput("reset rbusy", rbusy, 0);
        rst = 1'b0;
        tick();

        // Directed vector table
        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i].we, vecs[i].waddr, vecs[i].wdata, vecs[i].ra0, vecs[i].ra1,
                          vecs[i].iv, vecs[i].ird, vecs[i].fl);
            #1;
            checkOutput($sformatf("vec%0d rdata0", i), rdata[31:0], vecs[i].exp0);
            checkOutput($sformatf("vec%0d rdata1", i), rdata[63:32], vecs[i].exp1);
            checkOutput($sformatf("vec%0d rbusy", i), rbusy, vecs[i].exp_busy);
            checkOutput($sformatf("vec%0d a0", i), a0, vecs[i].exp_a0);
            tick();
        end

        // Trigger pulse reaches x5 on the third edge
        applyStimulus(0, 0, 0, 5, 0, 0, 0, 0);
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        tick();
        #1;
        checkOutput("trig x5 before 3rd edge", rdata[31:0], 0);
        tick();
        #1;
        checkOutput("trig x5 after 3rd edge", rdata[31:0], 1);

        // Trigger colliding with writeback to x5
        tick();
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        tick();
        applyStimulus(1, 5, 32'h9, 5, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 5, 0, 0, 0, 0);
        #1;
        checkOutput("collide x5 writeback wins", rdata[31:0], 32'h9);
        tick();
        #1;
        checkOutput("collide x5 deferred set", rdata[31:0], 1);

        // Reset mid-run with busy register and pending trigger
        tick();
        trigger = 1'b1;
        applyStimulus(0, 0, 0, 3, 0, 1, 3, 0);
        tick();
        trigger = 1'b0;
        applyStimulus(0, 0, 0, 3, 0, 0, 0, 0);
        tick();
        #1;
        checkOutput("pre-reset rbusy x3", rbusy, 2'b01);
        checkOutput("pre-reset rdata x3", rdata[31:0], 32'hDEAD);
        rst = 1'b1;
        #1;
        checkOutput("mid reset a0", a0, 0);
        checkOutput("mid reset rdata x3", rdata[31:0], 0);
        checkOutput("mid reset rbusy", rbusy, 0);
        tick();
        rst = 1'b0;
        applyStimulus(0, 0, 0, 5, 0, 0, 0, 0);
        tick();
        tick();
        tick();
        #1;
        checkOutput("pending trigger discarded", rdata[31:0], 0);

        // Randomized run against the reference model
        tick();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        for (int r = 0; r < 32; r++) begin
            m_regs[r] = 0;
            m_busy[r] = 0;
        end
        for (int c = 0; c < 300; c++) begin
            rw   = 1'($urandom_range(0, 1));
            rwa  = 5'($urandom_range(0, 15));
            rwd  = $urandom;
            rr0  = 5'($urandom_range(0, 15));
            rr1  = 5'($urandom_range(0, 15));
            riv  = ($urandom_range(0, 2) == 0);
            rird = 5'($urandom_range(0, 15));
            rfl  = ($urandom_range(0, 15) == 0);
            applyStimulus(rw, rwa, rwd, rr0, rr1, riv, rird, rfl);
            #1;
            exp_b[0] = (rr0 != 0) && m_busy[rr0] && !(rw && rwa == rr0);
            exp_b[1] = (rr1 != 0) && m_busy[rr1] && !(rw && rwa == rr1);
            checkOutput($sformatf("rand%0d rdata0", c), rdata[31:0], model_read(rr0, rw, rwa, rwd));
            checkOutput($sformatf("rand%0d rdata1", c), rdata[63:32], model_read(rr1, rw, rwa, rwd));
            checkOutput($sformatf("rand%0d rbusy", c), rbusy, exp_b);
            checkOutput($sformatf("rand%0d a0", c), a0, m_regs[10]);
            if (rw && rwa != 0) m_regs[rwa] = rwd;
            if (rfl) begin
                for (int r = 0; r < 32; r++) m_busy[r] = 0;
            end else if (rw) begin
                m_busy[rwa] = 0;
            end
            if (riv && rird != 0) m_busy[rird] = 1;
            tick();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        // Three-port 64-bit instance
        tick();
        we64 = 1'b1; waddr64 = 5'd1; wdata64 = 64'hA5A5_0000_0000_5A5A;
        tick();
        waddr64 = 5'd2; wdata64 = 64'h0123_4567_89AB_CDEF;
        tick();
        we64 = 1'b0;
        raddr64 = {5'd1, 5'd2, 5'd1};
        #1;
        checkOutput("w64 port0 x1", rdata64[63:0], 64'hA5A5_0000_0000_5A5A);
        checkOutput("w64 port1 x2", rdata64[127:64], 64'h0123_4567_89AB_CDEF);
        checkOutput("w64 port2 x1", rdata64[191:128], 64'hA5A5_0000_0000_5A5A);
        checkOutput("w64 rbusy", rbusy64, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
